// File: rtl/i2c_line_packer.sv
// Packs 32-bit I2C frames into 128-bit SDRAM lines, four frames per line, and issues one write per line.
// Optional feature macro READBACK_VERIFY_EN adds a read-back compare of every written line.
module i2c_line_packer #(
  parameter logic [21:0] BASE_ADDR = 22'd1,
  parameter logic [21:0] END_ADDR  = 22'd1023,
  parameter logic [21:0] ADDR_STEP = 22'd1
) (
  input  logic         iclk,
  input  logic         ireset_n,
  input  logic         iframe_valid,
  input  logic [31:0]  iframe_data,
  input  logic         iflush,
  output logic         owrite_req,
  output logic [21:0]  owrite_address,
  output logic [127:0] owrite_data,
  input  logic         iwrite_ack,
  output logic         oread_req,
  output logic [21:0]  oread_address,
  input  logic [127:0] iread_data,
  input  logic         iread_ack,
  output logic [2:0]   ofill,
  output logic         obusy,
  output logic         ooverflow,
  output logic         omismatch
);

`ifdef READBACK_VERIFY_EN
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  state_t         state, state_nxt;
  logic           frame_valid_d;
  logic           frame_stb;
  logic [127:0]   acc, acc_nxt;
  logic [127:0]   staging;
  logic [2:0]     fill_nxt;
  logic           commit;

  // The incoming frame lands in its slot before the commit decision, so a
  // same-cycle flush includes it.
  always_comb begin
    frame_stb = iframe_valid & ~frame_valid_d;
    acc_nxt   = acc;
    if (frame_stb) acc_nxt[{ofill[1:0], 5'd0} +: 32] = iframe_data;
    fill_nxt  = ofill + {2'b00, frame_stb};
    commit    = (fill_nxt == 3'd4) | (iflush & (fill_nxt != 3'd0));
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (commit) state_nxt = WRITE;
`ifdef READBACK_VERIFY_EN
      WRITE:  if (iwrite_ack) state_nxt = VERIFY;
      VERIFY: if (iread_ack) state_nxt = DONE;
`else
      WRITE:  if (iwrite_ack) state_nxt = DONE;
`endif
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator is cleared on every commit, so unfilled slots of a flushed line read as zero.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      frame_valid_d  <= 1'b0;
      acc            <= '0;
      ofill          <= '0;
      staging        <= '0;
      ooverflow      <= 1'b0;
      owrite_address <= BASE_ADDR;
    end else begin
      frame_valid_d <= iframe_valid;
      if (commit) begin
        acc   <= '0;
        ofill <= '0;
        if (state == IDLE) staging   <= acc_nxt;
        else               ooverflow <= 1'b1;
      end else begin
        acc   <= acc_nxt;
        ofill <= fill_nxt;
      end
      if (state == DONE)
        owrite_address <= (owrite_address == END_ADDR) ? BASE_ADDR : owrite_address + ADDR_STEP;
    end
  end

`ifdef READBACK_VERIFY_EN
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) omismatch <= 1'b0;
    else if (state == VERIFY && iread_ack && iread_data != staging) omismatch <= 1'b1;
  end
  assign oread_req = (state == VERIFY);
`else
  logic unused_rd;
  assign unused_rd = ^{iread_data, iread_ack};
  assign omismatch = 1'b0;
  assign oread_req = 1'b0;
`endif

  assign owrite_req    = (state == WRITE);
  assign owrite_data   = staging;
  assign oread_address = owrite_address;
  assign obusy         = (state != IDLE);

endmodule
